dcm_ctrl: RTL and testbench

Speed-selection controller for the `dcm` clock-divider block. It turns asynchronous up/down button levels and a direct-load request into single-cycle `update` pulses carrying a new 3-bit program. It then confirms the change against `dcm`'s `prog_out` feedback, retries on mismatch and rate-limits further changes. It sits between the board inputs and `dcm`, driving `dcm.update` and `dcm.prog_in`.

---
 rtl/dcm_pkg.sv | 24 ++
 rtl/dcm_ctrl_sync_edge.sv | 30 +++
 rtl/dcm_ctrl.sv | 153 +++++++++++++++
 tb/tb_dcm_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_pkg.sv
// Shared definitions for the dcm speed controller: state encodings, program
// limits and the saturating step helpers.
package dcm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam logic [2:0] PROG_MIN = 3'd0;
    localparam logic [2:0] PROG_MAX = 3'd7;

    function automatic logic [2:0] satInc(input logic [2:0] v);
        return (v == PROG_MAX) ? v : v + 3'd1;
    endfunction

    function automatic logic [2:0] satDec(input logic [2:0] v);
        return (v == PROG_MIN) ? v : v - 3'd1;
    endfunction

endpackage

// File: rtl/dcm_ctrl_sync_edge.sv
// Two-flop synchronizer for a raw button level followed by a registered
// rising-edge detect, giving a one-cycle event per press.
module sync_edge
    import dcm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= level_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/dcm_ctrl.sv
// Speed-selection controller for dcm: turns button presses and direct loads
// into update pulses, verifies them against prog_fb, retries and rate-limits.
module dcm_ctrl
    import dcm_pkg::*;
#(
    parameter int VERIFY_CYC  = 4,
    parameter int MAX_RETRY   = 2,
    parameter int HOLDOFF_CYC = 10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       set_valid,
    input  logic [2:0] set_val,
    input  logic       clr_err,
    input  logic [2:0] prog_fb,
    output logic       update,
    output logic [2:0] prog_in,
    output logic [2:0] speed,
    output logic       busy,
    output logic       err
);

    localparam logic [31:0] VERIFY_LAST = 32'(VERIFY_CYC - 1);
    localparam logic [31:0] RETRY_LIM   = 32'(MAX_RETRY);
    localparam logic [31:0] HOLD_LOAD   = 32'(HOLDOFF_CYC - 1);

    logic inc_ev;
    logic dec_ev;

    sync_edge u_inc_sync (
        .clock   (clock),
        .reset   (reset),
        .level_i (inc),
        .rise_o  (inc_ev)
    );

    sync_edge u_dec_sync (
        .clock   (clock),
        .reset   (reset),
        .level_i (dec),
        .rise_o  (dec_ev)
    );

    state_e      state_q;
    logic [2:0]  prog_q;
    logic [2:0]  speed_q;
    logic        update_q;
    logic        busy_q;
    logic        err_q;
    logic [31:0] vcnt_q;
    logic [31:0] retry_q;
    logic [31:0] hold_q;

    logic [2:0] target_d;
    logic       take_d;

    // A direct load outranks button events; opposing events cancel each other.
    always_comb begin
        target_d = speed_q;
        take_d   = 1'b0;
        if (set_valid) begin
            target_d = set_val;
            take_d   = 1'b1;
        end else if (inc_ev && !dec_ev) begin
            target_d = satInc(speed_q);
            take_d   = 1'b1;
        end else if (dec_ev && !inc_ev) begin
            target_d = satDec(speed_q);
            take_d   = 1'b1;
        end
        if (target_d == speed_q) begin
            take_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            prog_q   <= 3'd0;
            speed_q  <= 3'd0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            vcnt_q   <= '0;
            retry_q  <= '0;
            hold_q   <= '0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_d) begin
                        prog_q  <= target_d;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    update_q <= 1'b1;
                    vcnt_q   <= '0;
                    state_q  <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (prog_fb == prog_q) begin
                        speed_q <= prog_q;
                        hold_q  <= HOLD_LOAD;
                        state_q <= ST_HOLDOFF;
                    end else if (vcnt_q == VERIFY_LAST) begin
                        if (retry_q < RETRY_LIM) begin
                            retry_q <= retry_q + 32'd1;
                            state_q <= ST_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ST_ERROR;
                        end
                    end else begin
                        vcnt_q <= vcnt_q + 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    // Only a direct load may cut the rate limit short.
                    if (set_valid && take_d) begin
                        prog_q  <= set_val;
                        retry_q <= '0;
                        state_q <= ST_ISSUE;
                    end else if (hold_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q - 32'd1;
                    end
                end
                ST_ERROR: begin
                    if (clr_err) begin
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign update  = update_q;
    assign prog_in = prog_q;
    assign speed   = speed_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dcm_ctrl.sv
// Scoreboard bench for dcm_ctrl: stimulus pushes expected update transactions,
// a monitor pops and checks them whenever the DUT pulses update.
module tb_dcm_ctrl;

    localparam int VC = 4;
    localparam int MR = 2;
    localparam int HC = 8;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       inc       = 1'b0;
    logic       dec       = 1'b0;
    logic       set_valid = 1'b0;
    logic [2:0] set_val   = 3'd0;
    logic       clr_err   = 1'b0;
    logic [2:0] prog_fb;
    logic       update;
    logic [2:0] prog_in;
    logic [2:0] speed;
    logic       busy;
    logic       err;

    dcm_ctrl #(
        .VERIFY_CYC  (VC),
        .MAX_RETRY   (MR),
        .HOLDOFF_CYC (HC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inc       (inc),
        .dec       (dec),
        .set_valid (set_valid),
        .set_val   (set_val),
        .clr_err   (clr_err),
        .prog_fb   (prog_fb),
        .update    (update),
        .prog_in   (prog_in),
        .speed     (speed),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Behavioural dcm: latches prog_in on update; can be forced stuck at 0.
    logic [2:0] fbReg;
    logic       stuckFb = 1'b0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fbReg <= 3'd0;
        else if (update) fbReg <= prog_in;
    end
    assign prog_fb = stuckFb ? 3'd0 : fbReg;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] prog;
        logic [2:0] spd;
    } exp_t;

    exp_t expQ[$];
    int   stampQ[$];
    int   modelSpeed = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // kind: 0 direct load, 1 inc, 2 dec, 3 inc+dec together
    function automatic int refTarget(input int kind, input int val, input int spd);
        case (kind)
            0:       return val;
            1:       return (spd < 7) ? spd + 1 : 7;
            2:       return (spd > 0) ? spd - 1 : 0;
            default: return spd;
        endcase
    endfunction

    task automatic predict(input int kind, input int val);
        int tgt;
        tgt = refTarget(kind, val, modelSpeed);
        if (tgt != modelSpeed) begin
            expQ.push_back('{prog: 3'(tgt), spd: 3'(tgt)});
            modelSpeed = tgt;
        end
    endtask

    task automatic applyStimulus(input int kind, input int val);
        @(negedge clock);
        if (kind == 0) begin
            set_valid = 1'b1;
            set_val   = 3'(val);
            @(negedge clock);
            set_valid = 1'b0;
        end else begin
            inc = (kind == 1 || kind == 3);
            dec = (kind == 2 || kind == 3);
            repeat (4) @(negedge clock);
            inc = 1'b0;
            dec = 1'b0;
            repeat (3) @(negedge clock);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        repeat (3) @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) failNow("idleWait");
        repeat (2) @(negedge clock);
    endtask

    task automatic waitSpeed(input int v);
        int n;
        n = 0;
        while (speed != 3'(v) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (speed != 3'(v)) failNow("speedWait");
    endtask

    // Monitor: every update pulse must match the oldest expected transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && update) begin
                stampQ.push_back(cyc);
                if (expQ.size() == 0) begin
                    failNow("unexpectedUpdate");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("progIn", prog_in, e.prog);
                    @(negedge clock);
                    checkOutput("updateWidth", update, 0);
                    @(negedge clock);
                    checkOutput("commitSpeed", speed, e.spd);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int n;
        int kind;
        int val;

        repeat (3) @(negedge clock);
        checkOutput("rstUpdate", update, 0);
        checkOutput("rstProgIn", prog_in, 0);
        checkOutput("rstSpeed", speed, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstErr", err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single increment with latency and busy-through-holdoff checks.
        stampQ.delete();
        predict(1, 0);
        @(negedge clock);
        c0  = cyc;
        inc = 1'b1;
        repeat (4) @(negedge clock);
        inc = 1'b0;
        waitSpeed(1);
        checkOutput("busyHoldoff", busy, 1);
        waitIdle();
        checkOutput("incPulses", stampQ.size(), 1);
        if (stampQ.size() > 0) checkOutput("incLatency", stampQ[0], c0 + 4);
        checkOutput("incSpeed", speed, modelSpeed);

        // inc during holdoff is dropped.
        predict(0, 2);
        @(negedge clock);
        set_valid = 1'b1;
        set_val   = 3'd2;
        @(negedge clock);
        set_valid = 1'b0;
        waitSpeed(2);
        inc = 1'b1;
        repeat (3) @(negedge clock);
        inc = 1'b0;
        waitIdle();
        checkOutput("holdoffIncDrop", speed, 2);
        checkOutput("holdoffPending", expQ.size(), 0);

        // Direct load bypasses holdoff.
        stampQ.delete();
        predict(0, 4);
        applyStimulus(0, 4);
        waitSpeed(4);
        predict(0, 5);
        set_valid = 1'b1;
        set_val   = 3'd5;
        @(negedge clock);
        set_valid = 1'b0;
        waitIdle();
        checkOutput("bypassSpeed", speed, 5);
        checkOutput("bypassPulses", stampQ.size(), 2);
        if (stampQ.size() == 2) checkOutput("bypassGap", stampQ[1] - stampQ[0], 4);

        // Saturation at both ends.
        predict(0, 7);
        applyStimulus(0, 7);
        waitIdle();
        stampQ.delete();
        predict(1, 0);
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("satHighPulses", stampQ.size(), 0);
        checkOutput("satHighSpeed", speed, 7);
        predict(0, 0);
        applyStimulus(0, 0);
        waitIdle();
        stampQ.delete();
        predict(2, 0);
        applyStimulus(2, 0);
        waitIdle();
        checkOutput("satLowPulses", stampQ.size(), 0);
        checkOutput("satLowSpeed", speed, 0);

        // Simultaneous inc and dec cancel.
        predict(0, 3);
        applyStimulus(0, 3);
        waitIdle();
        stampQ.delete();
        applyStimulus(3, 0);
        waitIdle();
        checkOutput("bothPulses", stampQ.size(), 0);
        checkOutput("bothSpeed", speed, 3);

        // Retry exhaustion into ERROR with feedback stuck at 0.
        predict(0, 0);
        applyStimulus(0, 0);
        waitIdle();
        stuckFb = 1'b1;
        stampQ.delete();
        for (int i = 0; i < 1 + MR; i++) expQ.push_back('{prog: 3'd3, spd: 3'd0});
        applyStimulus(0, 3);
        n = 0;
        while (!err && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!err) failNow("errWait");
        repeat (10) @(negedge clock);
        checkOutput("retryPulses", stampQ.size(), 1 + MR);
        if (stampQ.size() == 3) begin
            checkOutput("retryGap1", stampQ[1] - stampQ[0], VC + 1);
            checkOutput("retryGap2", stampQ[2] - stampQ[1], VC + 1);
        end
        checkOutput("errFlag", err, 1);
        checkOutput("errBusy", busy, 0);
        checkOutput("errSpeed", speed, 0);
        checkOutput("errProgIn", prog_in, 3);
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
        @(negedge clock);
        checkOutput("clrErr", err, 0);
        checkOutput("clrSpeed", speed, 0);
        checkOutput("clrPending", expQ.size(), 0);

        // Asynchronous reset during VERIFY.
        expQ.push_back('{prog: 3'd3, spd: 3'd0});
        applyStimulus(0, 3);
        n = 0;
        while (!update && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!update) failNow("updateWait");
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("abortUpdate", update, 0);
        checkOutput("abortProgIn", prog_in, 0);
        checkOutput("abortSpeed", speed, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortErr", err, 0);
        repeat (3) @(negedge clock);
        reset   = 1'b1;
        stuckFb = 1'b0;
        modelSpeed = 0;
        repeat (2) @(negedge clock);

        // Randomized operations against the reference model.
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 3);
            val  = $urandom_range(0, 7);
            if (kind != 3) predict(kind, val);
            applyStimulus(kind, val);
            waitIdle();
            checkOutput("randSpeed", speed, modelSpeed);
            checkOutput("randPending", expQ.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
